// File: rtl/vend_controller.sv
// Vending sequencer: coin credit accumulation, vend handshake and greedy change return.
// Build with VEND_TIMEOUT_EN defined to add the idle refund timeout (TIMEOUT_CYCLES).
module vend_controller #(
  parameter int unsigned PRICE0         = 15,
  parameter int unsigned PRICE1         = 20,
  parameter int unsigned PRICE2         = 25,
  parameter int unsigned PRICE3         = 30,
  parameter int unsigned CREDIT_MAX     = 40,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       nickel,
  input  logic       dime,
  input  logic       quarter,
  input  logic [1:0] sel,
  input  logic       sel_valid,
  input  logic       cancel,
  input  logic       dispense_done,
  output logic       dispense_req,
  output logic [1:0] dispense_id,
  output logic       ret_nickel,
  output logic       ret_dime,
  output logic       ret_quarter,
  output logic       coin_reject,
  output logic [5:0] credit,
  output logic       busy
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DISPENSE = 2'd1;
  localparam logic [1:0] ST_CHANGE   = 2'd2;
  localparam logic [6:0] CREDIT_LIMIT = 7'(CREDIT_MAX);

  logic [1:0] state_q, state_d;
  logic [5:0] credit_q, credit_d;
  logic       dreq_q, dreq_d;
  logic [1:0] did_q, did_d;
  logic       rn_q, rn_d;
  logic       rd_q, rd_d;
  logic       rq_q, rq_d;
  logic       rej_q, rej_d;
  logic       busy_q, busy_d;

  logic [2:0] coin_vec_s;
  logic [5:0] coin_val_s;
  logic       coin_any_s;
  logic       coin_one_s;
  logic       coin_fit_s;
  logic       coin_acc_s;
  logic       timeout_s;
  logic [5:0] price_s;

  function automatic logic [5:0] price_of(input logic [1:0] idx);
    case (idx)
      2'd0:    price_of = 6'(PRICE0);
      2'd1:    price_of = 6'(PRICE1);
      2'd2:    price_of = 6'(PRICE2);
      default: price_of = 6'(PRICE3);
    endcase
  endfunction

  // Coin decode; a coin is only accepted when nothing of higher priority acts this cycle.
  always_comb begin
    coin_vec_s = {nickel, dime, quarter};
    coin_any_s = |coin_vec_s;
    coin_val_s = 6'd0;
    coin_one_s = 1'b0;
    case (coin_vec_s)
      3'b100:  begin coin_val_s = 6'd1; coin_one_s = 1'b1; end
      3'b010:  begin coin_val_s = 6'd2; coin_one_s = 1'b1; end
      3'b001:  begin coin_val_s = 6'd5; coin_one_s = 1'b1; end
      default: begin coin_val_s = 6'd0; coin_one_s = 1'b0; end
    endcase
    coin_fit_s = (({1'b0, credit_q} + {1'b0, coin_val_s}) <= CREDIT_LIMIT);
    price_s    = price_of(sel);
    coin_acc_s = (state_q == ST_IDLE) && !sel_valid && !cancel && !timeout_s
                 && coin_one_s && coin_fit_s;
  end

`ifdef VEND_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;

  assign timeout_s = (state_q == ST_IDLE) && (credit_q != 6'd0) && (idle_cnt_q == CNT_LAST);

  // Idle counter: runs while credit sits in IDLE, cleared by an accepted coin or leaving IDLE.
  always_comb begin
    if ((state_q == ST_IDLE) && (state_d == ST_IDLE) && (credit_q != 6'd0) && !coin_acc_s) begin
      idle_cnt_d = timeout_s ? idle_cnt_q : idle_cnt_q + CNT_W'(1);
    end else begin
      idle_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  logic unused_timeout_s;
  assign timeout_s        = 1'b0;
  assign unused_timeout_s = ^32'(TIMEOUT_CYCLES);
`endif

  // Next-state and registered-output logic for IDLE / DISPENSE / CHANGE.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    dreq_d   = dreq_q;
    did_d    = did_q;
    rn_d     = 1'b0;
    rd_d     = 1'b0;
    rq_d     = 1'b0;
    rej_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_valid) begin
          rej_d = coin_any_s;
          if (credit_q >= price_s) begin
            credit_d = credit_q - price_s;
            did_d    = sel;
            dreq_d   = 1'b1;
            state_d  = ST_DISPENSE;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (cancel || timeout_s) begin
          rej_d = coin_any_s;
          if (credit_q != 6'd0) begin
            state_d = ST_CHANGE;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (coin_acc_s) begin
          credit_d = credit_q + coin_val_s;
        end else begin
          rej_d = coin_any_s;
        end
      end
      ST_DISPENSE: begin
        rej_d = coin_any_s;
        if (dispense_done) begin
          dreq_d  = 1'b0;
          state_d = ST_CHANGE;
        end else begin
          state_d = ST_DISPENSE;
        end
      end
      ST_CHANGE: begin
        rej_d = coin_any_s;
        if (credit_q >= 6'd5) begin
          rq_d     = 1'b1;
          credit_d = credit_q - 6'd5;
        end else if (credit_q >= 6'd2) begin
          rd_d     = 1'b1;
          credit_d = credit_q - 6'd2;
        end else if (credit_q != 6'd0) begin
          rn_d     = 1'b1;
          credit_d = credit_q - 6'd1;
        end else begin
          credit_d = credit_q;
        end
        if (credit_d == 6'd0) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CHANGE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        credit_d = 6'd0;
        dreq_d   = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      credit_q <= 6'd0;
      dreq_q   <= 1'b0;
      did_q    <= 2'd0;
      rn_q     <= 1'b0;
      rd_q     <= 1'b0;
      rq_q     <= 1'b0;
      rej_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      dreq_q   <= dreq_d;
      did_q    <= did_d;
      rn_q     <= rn_d;
      rd_q     <= rd_d;
      rq_q     <= rq_d;
      rej_q    <= rej_d;
      busy_q   <= busy_d;
    end
  end

  assign dispense_req = dreq_q;
  assign dispense_id  = did_q;
  assign ret_nickel   = rn_q;
  assign ret_dime     = rd_q;
  assign ret_quarter  = rq_q;
  assign coin_reject  = rej_q;
  assign credit       = credit_q;
  assign busy         = busy_q;

endmodule
